// File: rtl/weight_rom_scheduler.sv
// weight_rom_scheduler: round-robin sharing of one weight ROM between four burst requesters.
// Define WEIGHT_SCHED_FIXED_PRIO_EN for fixed priority (requester 0 highest) instead of round-robin.
module weight_rom_scheduler #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int LEN_W  = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [3:0]            req,
  input  logic [4*ADDR_W-1:0]   req_base,
  input  logic [4*LEN_W-1:0]    req_len,
  output logic [3:0]            grant,
  output logic [ADDR_W-1:0]     rom_address,
  output logic                  rom_enable,
  input  logic [DATA_W-1:0]     rom_data,
  output logic [DATA_W-1:0]     weight_data,
  output logic                  weight_valid,
  output logic                  weight_last,
  output logic [1:0]            weight_owner
);
  typedef enum logic [1:0] {IDLE, BURST, RELEASE} state_t;
  state_t state_q, state_d;
  logic [1:0] win_q, win_d, pick;
  logic [LEN_W-1:0] len_q, len_d, cnt_q, cnt_d;
  logic [3:0] grant_d;
  logic [ADDR_W-1:0] addr_d;
  logic en_d, wv_d, wl_d;
  logic [DATA_W-1:0] wd_d;
  logic [1:0] wo_d;
`ifdef WEIGHT_SCHED_FIXED_PRIO_EN
  always_comb pick = req[0] ? 2'd0 : req[1] ? 2'd1 : req[2] ? 2'd2 : 2'd3;
`else
  logic [1:0] ptr_q, ptr_d;
  // Scan downwards so the id closest to the pointer is the last one written.
  always_comb begin
    pick = ptr_q;
    for (int k = 3; k >= 0; k--) if (req[ptr_q + 2'(k)]) pick = ptr_q + 2'(k);
  end
  assign ptr_d = (state_q == BURST && (!req[win_q] || cnt_q == len_q)) ? win_q + 2'd1 : ptr_q;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) ptr_q <= '0;
    else ptr_q <= ptr_d;
`endif
  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    grant_d = grant;
    addr_d  = rom_address;
    en_d    = rom_enable;
    wd_d    = weight_data;
    wv_d    = 1'b0;
    wl_d    = 1'b0;
    wo_d    = weight_owner;
    unique case (state_q)
      IDLE: if (|req) begin
        state_d = BURST;
        win_d   = pick;
        grant_d = 4'b1 << pick;
        addr_d  = req_base[pick*ADDR_W +: ADDR_W];
        len_d   = req_len[pick*LEN_W +: LEN_W];
        cnt_d   = '0;
        en_d    = 1'b1;
      end
      BURST: begin
        wd_d = rom_data;
        wv_d = 1'b1;
        wo_d = win_q;
        // A dropped request wins over completion: the word goes out unmarked.
        if (!req[win_q]) begin
          state_d = IDLE;
          en_d    = 1'b0;
          grant_d = '0;
        end else if (cnt_q == len_q) begin
          state_d = RELEASE;
          en_d    = 1'b0;
          wl_d    = 1'b1;
        end else begin
          cnt_d  = cnt_q + 1'b1;
          addr_d = rom_address + 1'b1;
        end
      end
      RELEASE: begin
        state_d = IDLE;
        grant_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q      <= IDLE;
      win_q        <= '0;
      len_q        <= '0;
      cnt_q        <= '0;
      grant        <= '0;
      rom_address  <= '0;
      rom_enable   <= 1'b0;
      weight_data  <= '0;
      weight_valid <= 1'b0;
      weight_last  <= 1'b0;
      weight_owner <= '0;
    end else begin
      state_q      <= state_d;
      win_q        <= win_d;
      len_q        <= len_d;
      cnt_q        <= cnt_d;
      grant        <= grant_d;
      rom_address  <= addr_d;
      rom_enable   <= en_d;
      weight_data  <= wd_d;
      weight_valid <= wv_d;
      weight_last  <= wl_d;
      weight_owner <= wo_d;
    end
endmodule
